seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 16 +
 rtl/sub_unit.sv | 15 +
 rtl/seq_divider.sv | 121 ++++++++++++
 tb/tb_seq_divider.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: default width, FSM encoding
// and the iteration-counter width helper.
package div_pkg;

  localparam int DIV_N = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Counter must reach N, so it needs ceil(log2(N+1)) bits.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sub_unit.sv
// Combinational trial subtractor used by each restoring-division step.
module sub_unit #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  always_comb begin
    {borrow, diff} = {1'b0, a} - {1'b0, b};
  end

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring shift-subtract divider: one quotient bit per RUN cycle,
// results committed to the outputs only on entry into DONE.
module seq_divider
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  prem_q, prem_d;
  logic [N-1:0]  shq_q, shq_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [N:0]    trial;
  logic [N:0]    diff;
  logic          borrow;
  logic          accept;
  logic          diff_msb_unused;

  // shq_q shifts dividend bits out of the top while quotient bits enter at the bottom.
  assign trial  = {prem_q, shq_q[N-1]};
  assign accept = start && (state_q != ST_RUN);

  sub_unit #(.W(N + 1)) u_sub (
    .a      (trial),
    .b      ({1'b0, dvs_q}),
    .diff   (diff),
    .borrow (borrow)
  );

  // A kept difference is always below the divisor, so its top bit is zero.
  assign diff_msb_unused = diff[N];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    shq_d   = shq_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    if (accept) begin
      dvs_d  = divisor;
      shq_d  = dividend;
      prem_d = '0;
      cnt_d  = '0;
      if (divisor == '0) begin
        state_d = ST_DONE;
        quo_d   = '1;
        rem_d   = dividend;
        dbz_d   = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_DONE;
            quo_d   = shq_q;
            rem_d   = prem_q;
            dbz_d   = 1'b0;
          end else begin
            prem_d = borrow ? trial[N-1:0] : diff[N-1:0];
            shq_d  = {shq_q[N-2:0], ~borrow};
            cnt_d  = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      shq_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      shq_q   <= shq_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed scenarios plus a random sweep
// against plain integer division.
module tb_seq_divider;

  localparam int N = 8;
  localparam int LAT = N + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int total = 0;
  int bad = 0;
  bit busy_seen;

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Drives one start, scrambles operands after acceptance, and returns the
  // number of edges after the accepting edge until done is seen (-1 on timeout).
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, output int lat);
    start = 1'b1;
    dividend = a;
    divisor = b;
    busy_seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = N'($urandom);
    divisor = N'($urandom);
    lat = -1;
    for (int i = 0; i <= 40; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      if (busy) busy_seen = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    run_op(8'd100, 8'd7, lat);
    total++;
    if (lat !== LAT) begin bad++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
    total++;
    if (quotient !== 8'd14 || remainder !== 8'd2 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL basic_result: got q=%0d r=%0d dbz=%b want q=14 r=2 dbz=0", quotient, remainder, div_by_zero);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_in_done: got %b want 0", busy); end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || quotient !== 8'd14 || remainder !== 8'd2) begin
      bad++;
      $display("FAIL basic_hold: got done=%b q=%0d r=%0d want done=0 q=14 r=2", done, quotient, remainder);
    end
  endtask

  task automatic test_edges();
    logic [N-1:0] ta [3] = '{8'd255, 8'd5, 8'd255};
    logic [N-1:0] tb [3] = '{8'd1, 8'd9, 8'd255};
    logic [N-1:0] eq [3] = '{8'd255, 8'd0, 8'd1};
    logic [N-1:0] er [3] = '{8'd0, 8'd5, 8'd0};
    int lat;
    for (int k = 0; k < 3; k++) begin
      run_op(ta[k], tb[k], lat);
      total++;
      if (lat !== LAT || quotient !== eq[k] || remainder !== er[k] || div_by_zero !== 1'b0) begin
        bad++;
        $display("FAIL edge_%0d: %0d/%0d got lat=%0d q=%0d r=%0d dbz=%b want lat=%0d q=%0d r=%0d dbz=0",
                 k, ta[k], tb[k], lat, quotient, remainder, div_by_zero, LAT, eq[k], er[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_zero();
    int lat;
    run_op(8'd42, 8'd0, lat);
    total++;
    if (lat !== 0) begin bad++; $display("FAIL dbz_latency: got %0d want 0", lat); end
    total++;
    if (quotient !== 8'd255 || remainder !== 8'd42 || div_by_zero !== 1'b1) begin
      bad++;
      $display("FAIL dbz_result: got q=%0d r=%0d dbz=%b want q=255 r=42 dbz=1", quotient, remainder, div_by_zero);
    end
    total++;
    if (busy_seen) begin bad++; $display("FAIL dbz_busy: got busy seen=1 want 0"); end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_ignore();
    int lat = -1;
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i <= 40; i++) begin
      if (done) begin lat = i; break; end
      start = (i == 3);
      if (i == 3) begin dividend = 8'd50; divisor = 8'd0; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    total++;
    if (lat !== LAT || quotient !== 8'd14 || remainder !== 8'd2 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL busy_ignore: got lat=%0d q=%0d r=%0d dbz=%b want lat=%0d q=14 r=2 dbz=0",
               lat, quotient, remainder, div_by_zero, LAT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int lat;
    bit done_seen = 1'b0;
    start = 1'b1; dividend = 8'd77; divisor = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      bad++;
      $display("FAIL reset_abort_async: got busy=%b done=%b q=%0d r=%0d dbz=%b want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) done_seen = 1'b1;
    end
    total++;
    if (done_seen) begin bad++; $display("FAIL reset_abort_done: got done pulse want none"); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd200, 8'd3, lat);
    total++;
    if (lat !== LAT || quotient !== 8'd66 || remainder !== 8'd2 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_op: got lat=%0d q=%0d r=%0d dbz=%b want lat=%0d q=66 r=2 dbz=0",
               lat, quotient, remainder, div_by_zero, LAT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat1;
    int lat2;
    run_op(8'd20, 8'd3, lat1);
    total++;
    if (lat1 !== LAT || quotient !== 8'd6 || remainder !== 8'd2) begin
      bad++;
      $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d want lat=%0d q=6 r=2", lat1, quotient, remainder, LAT);
    end
    run_op(8'd9, 8'd2, lat2);
    total++;
    if (lat2 !== LAT || quotient !== 8'd4 || remainder !== 8'd1 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d dbz=%b want lat=%0d q=4 r=1 dbz=0",
               lat2, quotient, remainder, div_by_zero, LAT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [N-1:0] a;
    logic [N-1:0] b;
    int lat;
    int eq;
    int er;
    int el;
    for (int n = 0; n < 1000; n++) begin
      a = N'($urandom_range(0, 255));
      b = ($urandom_range(0, 15) == 0) ? '0 : N'($urandom_range(1, 255));
      if (b == 0) begin
        eq = 255; er = int'(a); el = 0;
      end else begin
        eq = int'(a) / int'(b); er = int'(a) % int'(b); el = LAT;
      end
      run_op(a, b, lat);
      total++;
      if (lat !== el || int'(quotient) !== eq || int'(remainder) !== er || div_by_zero !== (b == 0)) begin
        bad++;
        $display("FAIL rand_%0d: %0d/%0d got lat=%0d q=%0d r=%0d dbz=%b want lat=%0d q=%0d r=%0d",
                 n, a, b, lat, quotient, remainder, div_by_zero, el, eq, er);
      end
      if (b != 0) begin
        total++;
        if (int'(quotient) * int'(b) + int'(remainder) != int'(a) || int'(remainder) >= int'(b)) begin
          bad++;
          $display("FAIL rand_identity_%0d: %0d/%0d got q=%0d r=%0d", n, a, b, quotient, remainder);
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
